// File: rtl/imem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_access_arbiter
// Description : Shares a single-port, word-addressed instruction memory
//               between the fetch stage (read-only) and the program loader
//               (read/write). Fetch has priority, a starvation counter
//               guarantees the loader a slot, and a lock mode gives the
//               loader exclusive back-to-back access while stalling the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_access_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    // loader port
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic              ld_lock,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    // pipeline stall
    output logic              cpu_hold,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                 c_cnt_w    = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_max_wait = c_cnt_w'(MAX_WAIT);

    localparam logic [0:0] c_st_arb  = 1'b0;
    localparam logic [0:0] c_st_lock = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic [c_cnt_w-1:0] w_wait_cnt_nxt;
    logic               w_fetch_gnt;
    logic               w_ld_gnt;
    logic               w_cpu_hold;
    logic               r_fetch_valid;
    logic               r_ld_rvalid;

    // Grant decision, starvation counter update and lock entry/exit.
    // Grants are suppressed while reset is asserted so every output idles.
    always_comb begin
        w_fetch_gnt    = 1'b0;
        w_ld_gnt       = 1'b0;
        w_cpu_hold     = 1'b0;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = '0;
        if (rst_n) begin
            case (r_state)
                c_st_arb: begin
                    w_ld_gnt    = ld_req & (~fetch_req | (r_wait_cnt == c_max_wait));
                    w_fetch_gnt = fetch_req & ~w_ld_gnt;
                    // A refused loader ages toward a forced grant.
                    if (ld_req && !w_ld_gnt) begin
                        w_wait_cnt_nxt = (r_wait_cnt == c_max_wait) ? r_wait_cnt
                                                                    : r_wait_cnt + c_cnt_w'(1);
                    end
                    if (w_ld_gnt && ld_lock) begin
                        w_state_nxt = c_st_lock;
                    end
                end
                c_st_lock: begin
                    // Loader owns the memory; the final unlocked request is still served.
                    w_cpu_hold = 1'b1;
                    w_ld_gnt   = ld_req;
                    if (!ld_req || !ld_lock) begin
                        w_state_nxt = c_st_arb;
                    end
                end
                default: begin
                    w_state_nxt = c_st_arb;
                end
            endcase
        end
    end

    // Route the granted requester onto the memory port; idle drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_fetch_gnt) begin
            mem_addr = fetch_addr;
        end else if (w_ld_gnt) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    assign fetch_gnt  = w_fetch_gnt;
    assign ld_gnt     = w_ld_gnt;
    assign cpu_hold   = w_cpu_hold;
    assign mem_en     = w_fetch_gnt | w_ld_gnt;
    assign mem_we     = w_ld_gnt & ld_we;
    assign fetch_data = mem_rdata;
    assign ld_rdata   = mem_rdata;
    assign fetch_valid = r_fetch_valid;
    assign ld_rvalid   = r_ld_rvalid;

    // State, starvation counter and read-return flags (1-cycle memory latency).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_arb;
            r_wait_cnt    <= '0;
            r_fetch_valid <= 1'b0;
            r_ld_rvalid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_fetch_valid <= w_fetch_gnt;
            r_ld_rvalid   <= w_ld_gnt & ~ld_we;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_access_arbiter
// Description : Directed self-checking bench for imem_access_arbiter with a
//               behavioural 256-word synchronous memory behind it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_access_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              ld_req;
    logic              ld_we;
    logic              ld_lock;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              cpu_hold;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    imem_access_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .ld_req      (ld_req),
        .ld_we       (ld_we),
        .ld_lock     (ld_lock),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_gnt      (ld_gnt),
        .ld_rvalid   (ld_rvalid),
        .ld_rdata    (ld_rdata),
        .cpu_hold    (cpu_hold),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    function automatic logic [31:0] word(input int i);
        return 32'h1000_0000 + i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit exp_g;
        bit prev_g;
        for (int i = 0; i < 256; i++) mem[i] = word(i);
        mem_rdata  = '0;
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_req     = 1'b0;
        ld_we      = 1'b0;
        ld_lock    = 1'b0;
        ld_addr    = '0;
        ld_wdata   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted between a fetch grant and its return.
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = 8'd3;
        #1 check("t1_pre_gnt", fetch_gnt, 1);
        #3 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("t1_fetch_valid", fetch_valid, 0);
        check("t1_ld_rvalid",   ld_rvalid,   0);
        check("t1_fetch_gnt",   fetch_gnt,   0);
        check("t1_ld_gnt",      ld_gnt,      0);
        check("t1_cpu_hold",    cpu_hold,    0);
        check("t1_mem_en",      mem_en,      0);
        check("t1_mem_addr",    mem_addr,    0);
        fetch_req = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        #1 check("t1_no_late_valid", fetch_valid, 0);

        // Fetch alone: granted every cycle, data one cycle later.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fetch_req  = 1'b1;
            fetch_addr = ADDR_W'(i);
            #1;
            check("t2_gnt",  fetch_gnt, 1);
            check("t2_addr", mem_addr,  i);
            if (i > 0) begin
                check("t2_valid", fetch_valid, 1);
                check("t2_data",  fetch_data,  word(i - 1));
            end
        end
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        check("t2_valid_last", fetch_valid, 1);
        check("t2_data_last",  fetch_data,  word(3));

        // Contention: loader forced through every MAX_WAIT+1 cycles.
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            fetch_req  = 1'b1;
            fetch_addr = ADDR_W'(20 + k);
            ld_req     = 1'b1;
            ld_we      = 1'b0;
            ld_addr    = 8'd9;
            #1;
            exp_g = ((k % 5) == 4);
            check("t3_ld_gnt",    ld_gnt,    exp_g);
            check("t3_fetch_gnt", fetch_gnt, !exp_g);
            if (exp_g) check("t3_mem_addr", mem_addr, 9);
            if (k > 0) begin
                prev_g = (((k - 1) % 5) == 4);
                check("t3_ld_rvalid",    ld_rvalid,   prev_g);
                check("t3_fetch_valid",  fetch_valid, !prev_g);
                if (prev_g) check("t3_ld_rdata",   ld_rdata,   word(9));
                else        check("t3_fetch_data", fetch_data, word(20 + k - 1));
            end
        end
        @(negedge clk);
        fetch_req = 1'b0;
        ld_req    = 1'b0;

        // Loader write with fetch idle, then read it back.
        @(negedge clk);
        ld_req   = 1'b1;
        ld_we    = 1'b1;
        ld_addr  = 8'd5;
        ld_wdata = 32'hDEAD_BEEF;
        #1;
        check("t4_ld_gnt", ld_gnt,    1);
        check("t4_mem_we", mem_we,    1);
        check("t4_wdata",  mem_wdata, 32'hDEAD_BEEF);
        check("t4_addr",   mem_addr,  5);
        @(negedge clk);
        ld_we = 1'b0;
        #1;
        check("t4_no_wr_resp", ld_rvalid, 0);
        check("t4_rd_gnt",     ld_gnt,    1);
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        check("t4_rvalid", ld_rvalid, 1);
        check("t4_rdata",  ld_rdata,  32'hDEAD_BEEF);

        // Lock burst against a busy fetch stage.
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = 8'd40;
        ld_req     = 1'b1;
        ld_lock    = 1'b1;
        ld_we      = 1'b1;
        ld_addr    = 8'd0;
        ld_wdata   = 32'hA5A5_0000;
        n = 0;
        #1;
        while (!ld_gnt && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_wait_cycles", n, MAX_WAIT);
        check("t5_first_hold",  cpu_hold, 0);
        check("t5_first_addr",  mem_addr, 0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            ld_addr  = ADDR_W'(i);
            ld_wdata = 32'hA5A5_0000 + i;
            ld_lock  = (i != 7);
            #1;
            check("t5_hold",      cpu_hold,  1);
            check("t5_fetch_gnt", fetch_gnt, 0);
            check("t5_ld_gnt",    ld_gnt,    1);
            check("t5_mem_we",    mem_we,    1);
            check("t5_mem_addr",  mem_addr,  i);
        end
        @(negedge clk);
        ld_req  = 1'b0;
        ld_lock = 1'b0;
        ld_we   = 1'b0;
        #1;
        check("t5_exit_hold",      cpu_hold,  0);
        check("t5_exit_fetch_gnt", fetch_gnt, 1);
        @(negedge clk);
        fetch_req = 1'b0;
        ld_req    = 1'b1;
        ld_addr   = 8'd3;
        #1 check("t5_rd_gnt", ld_gnt, 1);
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        check("t5_rd_valid", ld_rvalid, 1);
        check("t5_rd_data",  ld_rdata,  32'hA5A5_0003);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
